// File: rtl/wash_pkg.sv
// Shared state encoding and default timing for the timed wash sequencer.
package wash_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SOAK  = 3'd1;
  localparam logic [2:0] ST_WASH  = 3'd2;
  localparam logic [2:0] ST_RINSE = 3'd3;
  localparam logic [2:0] ST_SPIN  = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SOAK  = ST_SOAK,
    WASH  = ST_WASH,
    RINSE = ST_RINSE,
    SPIN  = ST_SPIN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } wash_state_t;

  localparam int DEF_T_SOAK  = 8;
  localparam int DEF_T_WASH  = 12;
  localparam int DEF_T_RINSE = 10;
  localparam int DEF_T_SPIN  = 6;
  localparam int DEF_PRICE   = 2;

  function automatic logic is_run_phase(input wash_state_t s);
    return (s == SOAK) || (s == WASH) || (s == RINSE) || (s == SPIN);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Loadable down-counter for phase durations; holds while paused and stops at zero.
module wash_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!hold && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wash_ctrl_timed.sv
// Coin-operated washer sequencer: credit, SOAK/(WASH/RINSE)xN/SPIN phases, lid pause, done pulse.
module wash_ctrl_timed
  import wash_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int T_SOAK  = DEF_T_SOAK,
  parameter int T_WASH  = DEF_T_WASH,
  parameter int T_RINSE = DEF_T_RINSE,
  parameter int T_SPIN  = DEF_T_SPIN,
  parameter int PRICE   = DEF_PRICE,
  parameter int CRED_W  = 3,
  parameter int MAX_CYC = 3,
  parameter int CYC_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              moeda,
  input  logic              lid_r,
  input  logic [CYC_W-1:0]  n_ciclos,
  output logic              molho,
  output logic              lavar,
  output logic              enxague,
  output logic              centrifugar,
  output logic              pausar,
  output logic              parada,
  output logic [CRED_W-1:0] credito,
  output logic [CNT_W-1:0]  fase_restante
);

  wash_state_t       state, next_state, ret_phase;
  logic [CYC_W-1:0]  cyc_left, cyc_init;
  logic              start;
  logic              t_load, t_hold, t_zero;
  logic [CNT_W-1:0]  t_val, t_count;

  wash_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .hold     (t_hold),
    .count    (t_count),
    .zero     (t_zero)
  );

  // Requested repetitions clamped into 1..MAX_CYC.
  always_comb begin
    if (n_ciclos == '0)
      cyc_init = CYC_W'(1);
    else if (n_ciclos > CYC_W'(MAX_CYC))
      cyc_init = CYC_W'(MAX_CYC);
    else
      cyc_init = n_ciclos;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    t_load     = 1'b0;
    t_hold     = 1'b0;
    t_val      = '0;
    case (state)
      IDLE: begin
        if ((credito == CRED_W'(PRICE)) && !lid_r) begin
          start      = 1'b1;
          next_state = SOAK;
          t_load     = 1'b1;
          t_val      = CNT_W'(T_SOAK - 1);
        end
      end
      SOAK, WASH, RINSE, SPIN: begin
        // Lid wins over expiry: the timer freezes and the phase is resumed later.
        if (lid_r) begin
          next_state = PAUSE;
          t_hold     = 1'b1;
        end else if (t_zero) begin
          t_load = 1'b1;
          case (state)
            SOAK: begin
              next_state = WASH;
              t_val      = CNT_W'(T_WASH - 1);
            end
            WASH: begin
              next_state = RINSE;
              t_val      = CNT_W'(T_RINSE - 1);
            end
            RINSE: begin
              if (cyc_left > CYC_W'(1)) begin
                next_state = WASH;
                t_val      = CNT_W'(T_WASH - 1);
              end else begin
                next_state = SPIN;
                t_val      = CNT_W'(T_SPIN - 1);
              end
            end
            default: begin
              next_state = DONE;
              t_load     = 1'b0;
            end
          endcase
        end
      end
      PAUSE: begin
        t_hold = 1'b1;
        if (!lid_r)
          next_state = ret_phase;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ret_phase <= IDLE;
      credito   <= '0;
      cyc_left  <= '0;
    end else begin
      state <= next_state;
      if ((next_state == PAUSE) && (state != PAUSE))
        ret_phase <= state;
      if (start) begin
        credito  <= '0;
        cyc_left <= cyc_init;
      end else if ((state == IDLE) && moeda && (credito < CRED_W'(PRICE))) begin
        credito <= credito + 1'b1;
      end
      if ((state == RINSE) && (next_state == WASH))
        cyc_left <= cyc_left - 1'b1;
    end
  end

  assign molho         = (state == SOAK);
  assign lavar         = (state == WASH);
  assign enxague       = (state == RINSE);
  assign centrifugar   = (state == SPIN);
  assign pausar        = (state == PAUSE);
  assign parada        = (state == DONE);
  assign fase_restante = (is_run_phase(state) || (state == PAUSE)) ? t_count : '0;

endmodule
